// File: rtl/urv_defs.sv
// Shared uRV pipeline definitions used by the writeback stage.
//   - load funct3 encodings (FUNC_*)
//   - rd result-source encodings (RD_SOURCE_*)
//   - writeback FSM state type
//   - byte/half extension helpers used by the load aligner
package urv_defs;

    localparam logic [2:0] FUNC_LB  = 3'b000;
    localparam logic [2:0] FUNC_LH  = 3'b001;
    localparam logic [2:0] FUNC_LW  = 3'b010;
    localparam logic [2:0] FUNC_LBU = 3'b100;
    localparam logic [2:0] FUNC_LHU = 3'b101;

    localparam logic [1:0] RD_SOURCE_ALU     = 2'd0;
    localparam logic [1:0] RD_SOURCE_SHIFTER = 2'd1;
    localparam logic [1:0] RD_SOURCE_LOAD    = 2'd2;
    localparam logic [1:0] RD_SOURCE_MUL     = 2'd3;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

    // Extend a byte to 32 bits; sign-extends when sgn is set.
    function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    // Extend a halfword to 32 bits; sign-extends when sgn is set.
    function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/urv_load_align.sv
// Load data aligner: picks the addressed byte/halfword out of the raw load
// word and sign- or zero-extends it according to the load funct3.
// Ports:
//   fun   - load funct3 (LB/LH/LW/LBU/LHU; anything else returns the word)
//   addr  - byte address bits [1:0]
//   data  - raw 32-bit load word
//   value - aligned, extended 32-bit result
module urv_load_align
    import urv_defs::*;
(
    input  logic [2:0]  fun,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = data[7:0];
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        // addr[0] is irrelevant for halfwords: misaligned halves trap upstream.
        half_sel = addr[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        case (fun)
            FUNC_LB:  value = extend8(byte_sel, 1'b1);
            FUNC_LBU: value = extend8(byte_sel, 1'b0);
            FUNC_LH:  value = extend16(half_sel, 1'b1);
            FUNC_LHU: value = extend16(half_sel, 1'b0);
            default:  value = data;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback (W) stage. Captures the retiring instruction from execute,
// selects the rd value (ALU / shifter / multiplier / aligned load data),
// stalls the pipe while a load is outstanding and drives the register-file
// write port plus the W-stage bypass.
// Ports:
//   clk_i, rst_n_i                 - clock, asynchronous active-low reset
//   x_*                            - instruction descriptor from execute
//   x_stall_i                      - global stall; W register holds while high
//   w_shifter_rd_i, w_mul_rd_i     - shifter / multiplier results in the W cycle
//   dm_load_done_i, dm_data_l_i    - load completion strobe and raw load word
//   w_stall_req_o                  - load outstanding, stall the pipe
//   w_load_fault_o                 - one-cycle pulse when a load times out
//   rf_write_o, rf_rd_o, rf_value_o- register-file write port
//   w_bypass_rd_o, w_bypass_value_o- forwarding to decode/execute
module urv_writeback
    import urv_defs::*;
#(
    parameter int g_load_timeout  = 0,
    parameter int g_timeout_width = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_valid_i,
    input  logic        x_stall_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [1:0]  x_rd_source_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,
    input  logic [31:0] w_shifter_rd_i,
    input  logic [31:0] w_mul_rd_i,
    input  logic        dm_load_done_i,
    input  logic [31:0] dm_data_l_i,
    output logic        w_stall_req_o,
    output logic        w_load_fault_o,
    output logic        rf_write_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_value_o,
    output logic [4:0]  w_bypass_rd_o,
    output logic [31:0] w_bypass_value_o
);

    localparam logic [g_timeout_width-1:0] TMO_LIMIT = g_timeout_width'(g_load_timeout);

    logic                       vld_p0;
    logic [4:0]                 rd_p0;
    logic                       rd_write_p0;
    logic [1:0]                 rd_source_p0;
    logic [31:0]                rd_value_p0;
    logic [2:0]                 fun_p0;
    logic [1:0]                 dm_addr_p0;

    wb_state_t                  state, state_next;
    logic [g_timeout_width-1:0] tmo_cnt;

    logic                       capture, load_capture;
    logic                       in_wait, load_done, timeout_hit, is_load, write_en;
    logic [31:0]                load_value, result;

    assign capture      = !x_stall_i;
    assign load_capture = capture & x_valid_i & (x_rd_source_i == RD_SOURCE_LOAD);

    // ---- X -> W register boundary ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            vld_p0 <= 1'b0;
        else if (capture)
            vld_p0 <= x_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            rd_p0        <= x_rd_i;
            rd_write_p0  <= x_rd_write_i;
            rd_source_p0 <= x_rd_source_i;
            rd_value_p0  <= x_rd_value_i;
            fun_p0       <= x_fun_i;
            dm_addr_p0   <= x_dm_addr_i;
        end
    end

    // ---- W stage: load FSM and timeout ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state <= WB_IDLE;
        else
            state <= state_next;
    end

    assign in_wait   = (state == WB_WAIT_LOAD);
    // Load data only counts while a load is actually outstanding.
    assign load_done = in_wait & dm_load_done_i;
    assign timeout_hit = (g_load_timeout > 0) && in_wait && (tmo_cnt == TMO_LIMIT);

    always_comb begin
        state_next = state;
        case (state)
            WB_IDLE:
                if (load_capture)
                    state_next = WB_WAIT_LOAD;
            WB_WAIT_LOAD:
                // A load retiring this cycle may be replaced by another load.
                if (dm_load_done_i || timeout_hit)
                    state_next = load_capture ? WB_WAIT_LOAD : WB_IDLE;
            default:
                state_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            tmo_cnt <= '0;
        else if (g_load_timeout == 0 || !in_wait || dm_load_done_i || timeout_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // ---- W stage: result select and write port ----
    urv_load_align u_load_align (
        .fun   (fun_p0),
        .addr  (dm_addr_p0),
        .data  (dm_data_l_i),
        .value (load_value)
    );

    always_comb begin
        case (rd_source_p0)
            RD_SOURCE_SHIFTER: result = w_shifter_rd_i;
            RD_SOURCE_LOAD:    result = load_value;
            RD_SOURCE_MUL:     result = w_mul_rd_i;
            default:           result = rd_value_p0;
        endcase
    end

    assign is_load  = (rd_source_p0 == RD_SOURCE_LOAD);
    assign write_en = vld_p0 & rd_write_p0 & (rd_p0 != 5'd0) & (!is_load | load_done);

    // Done beats timeout when both land on the same cycle.
    assign w_stall_req_o    = in_wait & vld_p0 & !dm_load_done_i & !timeout_hit;
    assign w_load_fault_o   = timeout_hit & !dm_load_done_i;
    assign rf_write_o       = write_en;
    assign rf_rd_o          = vld_p0 ? rd_p0 : 5'd0;
    assign rf_value_o       = vld_p0 ? result : 32'd0;
    // Outstanding loads forward rd=0: the hazard is covered by the stall.
    assign w_bypass_rd_o    = write_en ? rd_p0 : 5'd0;
    assign w_bypass_value_o = rf_value_o;

endmodule

// File: tb/tb_urv_writeback.sv
module tb_urv_writeback;
    import urv_defs::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        x_valid_i;
    logic        ext_stall;
    logic        x_stall_i;
    logic [4:0]  x_rd_i;
    logic        x_rd_write_i;
    logic [1:0]  x_rd_source_i;
    logic [31:0] x_rd_value_i;
    logic [2:0]  x_fun_i;
    logic [1:0]  x_dm_addr_i;
    logic [31:0] w_shifter_rd_i;
    logic [31:0] w_mul_rd_i;
    logic        dm_load_done_i;
    logic [31:0] dm_data_l_i;
    logic        w_stall_req_o;
    logic        w_load_fault_o;
    logic        rf_write_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_value_o;
    logic [4:0]  w_bypass_rd_o;
    logic [31:0] w_bypass_value_o;

    int n_tests = 0;
    int n_fail  = 0;

    // The pipeline stalls whenever W asks for it, plus any external stall.
    assign x_stall_i = ext_stall | w_stall_req_o;

    urv_writeback #(.g_load_timeout(4), .g_timeout_width(8)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .x_valid_i        (x_valid_i),
        .x_stall_i        (x_stall_i),
        .x_rd_i           (x_rd_i),
        .x_rd_write_i     (x_rd_write_i),
        .x_rd_source_i    (x_rd_source_i),
        .x_rd_value_i     (x_rd_value_i),
        .x_fun_i          (x_fun_i),
        .x_dm_addr_i      (x_dm_addr_i),
        .w_shifter_rd_i   (w_shifter_rd_i),
        .w_mul_rd_i       (w_mul_rd_i),
        .dm_load_done_i   (dm_load_done_i),
        .dm_data_l_i      (dm_data_l_i),
        .w_stall_req_o    (w_stall_req_o),
        .w_load_fault_o   (w_load_fault_o),
        .rf_write_o       (rf_write_o),
        .rf_rd_o          (rf_rd_o),
        .rf_value_o       (rf_value_o),
        .w_bypass_rd_o    (w_bypass_rd_o),
        .w_bypass_value_o (w_bypass_value_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference load result using native signed C-like types for extension.
    function automatic logic [31:0] ref_load(input logic [2:0] fun, input logic [1:0] addr,
                                             input logic [31:0] data);
        logic [31:0] b_word;
        logic [31:0] h_word;
        byte         b;
        shortint     h;
        b_word = data >> (8 * int'(addr));
        h_word = data >> (16 * int'(addr[1]));
        b = byte'(b_word[7:0]);
        h = shortint'(h_word[15:0]);
        case (fun)
            3'b000:  return 32'(int'(b));
            3'b100:  return {24'd0, b_word[7:0]};
            3'b001:  return 32'(int'(h));
            3'b101:  return {16'd0, h_word[15:0]};
            default: return data;
        endcase
    endfunction

    task automatic drive_x(input logic v, input logic [4:0] rd, input logic wr, input logic [1:0] src,
                           input logic [31:0] val, input logic [2:0] fun, input logic [1:0] addr);
        x_valid_i = v; x_rd_i = rd; x_rd_write_i = wr; x_rd_source_i = src;
        x_rd_value_i = val; x_fun_i = fun; x_dm_addr_i = addr;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; ext_stall = 1'b0; dm_load_done_i = 1'b0; dm_data_l_i = 32'h0;
        w_shifter_rd_i = 32'h0; w_mul_rd_i = 32'h0;
        drive_x(1'b1, 5'd5, 1'b1, RD_SOURCE_ALU, 32'hDEAD_BEEF, 3'd0, 2'd0);
        repeat (3) @(posedge clk_i);
        #2;
        n_tests++;
        if ({w_stall_req_o, w_load_fault_o, rf_write_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got stall/fault/write=%b required 000",
                               {w_stall_req_o, w_load_fault_o, rf_write_o});
        end
        n_tests++;
        if ({rf_rd_o, rf_value_o, w_bypass_rd_o, w_bypass_value_o} !== 74'd0) begin
            n_fail++; $display("FAIL reset_data: got rd=%0d val=%h brd=%0d bval=%h required all 0",
                               rf_rd_o, rf_value_o, w_bypass_rd_o, w_bypass_value_o);
        end
        drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_alu();
        drive_x(1'b1, 5'd5, 1'b1, RD_SOURCE_ALU, 32'h1234_5678, 3'd0, 2'd0);
        tick(); #1;
        n_tests++;
        if ({rf_write_o, rf_rd_o, rf_value_o, w_stall_req_o, w_bypass_rd_o} !== {1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd5}) begin
            n_fail++; $display("FAIL alu_retire: got wr=%b rd=%0d val=%h stall=%b brd=%0d required 1 5 12345678 0 5",
                               rf_write_o, rf_rd_o, rf_value_o, w_stall_req_o, w_bypass_rd_o);
        end
        // External stall: W must hold the previous instruction.
        ext_stall = 1'b1;
        drive_x(1'b1, 5'd6, 1'b1, RD_SOURCE_ALU, 32'hAAAA_5555, 3'd0, 2'd0);
        tick(); #1;
        n_tests++;
        if ({rf_rd_o, rf_value_o} !== {5'd5, 32'h1234_5678}) begin
            n_fail++; $display("FAIL alu_hold: got rd=%0d val=%h required 5 12345678", rf_rd_o, rf_value_o);
        end
        ext_stall = 1'b0;
        tick(); #1;
        n_tests++;
        if ({rf_write_o, rf_rd_o, rf_value_o} !== {1'b1, 5'd6, 32'hAAAA_5555}) begin
            n_fail++; $display("FAIL alu_release: got wr=%b rd=%0d val=%h required 1 6 aaaa5555",
                               rf_write_o, rf_rd_o, rf_value_o);
        end
        drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
        tick();
    endtask

    task automatic test_shift();
        logic [1:0] srcs [3];
        srcs[0] = RD_SOURCE_ALU; srcs[1] = RD_SOURCE_SHIFTER; srcs[2] = RD_SOURCE_MUL;
        drive_x(1'b1, 5'd3, 1'b1, RD_SOURCE_SHIFTER, 32'h0000_0011, 3'd0, 2'd0);
        tick();
        w_shifter_rd_i = 32'hFFFF_FF80;
        #1;
        n_tests++;
        if ({rf_write_o, rf_rd_o, rf_value_o} !== {1'b1, 5'd3, 32'hFFFF_FF80}) begin
            n_fail++; $display("FAIL shift_retire: got wr=%b rd=%0d val=%h required 1 3 ffffff80",
                               rf_write_o, rf_rd_o, rf_value_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive_x(1'b1, 5'd0, 1'b1, srcs[i], 32'h0000_0042, 3'd0, 2'd0);
            tick();
            w_mul_rd_i = 32'h0000_0077;
            #1;
            n_tests++;
            if ({rf_write_o, w_bypass_rd_o} !== {1'b0, 5'd0}) begin
                n_fail++; $display("FAIL rd0_src%0d: got wr=%b brd=%0d required 0 0", i, rf_write_o, w_bypass_rd_o);
            end
        end
        drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
        tick();
    endtask

    task automatic test_load_align();
        logic [2:0]  funs  [5];
        logic [1:0]  addrs [5];
        logic [31:0] exps  [5];
        logic [2:0]  f;
        logic [1:0]  a;
        logic [31:0] d, e;
        funs[0] = FUNC_LB;  addrs[0] = 2'd2; exps[0] = 32'hFFFF_FFFF;
        funs[1] = FUNC_LBU; addrs[1] = 2'd3; exps[1] = 32'h0000_0080;
        funs[2] = FUNC_LH;  addrs[2] = 2'd2; exps[2] = 32'hFFFF_80FF;
        funs[3] = FUNC_LHU; addrs[3] = 2'd0; exps[3] = 32'h0000_7F01;
        funs[4] = FUNC_LW;  addrs[4] = 2'd1; exps[4] = 32'h80FF_7F01;
        // Directed cases, data arriving in the first W cycle (no stall).
        for (int i = 0; i < 5; i++) begin
            drive_x(1'b1, 5'(10 + i), 1'b1, RD_SOURCE_LOAD, 32'h0, funs[i], addrs[i]);
            tick();
            drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
            dm_data_l_i = 32'h80FF_7F01; dm_load_done_i = 1'b1;
            #1;
            n_tests++;
            if ({w_stall_req_o, rf_write_o, rf_value_o} !== {1'b0, 1'b1, exps[i]}) begin
                n_fail++; $display("FAIL load_align%0d: got stall=%b wr=%b val=%h required 0 1 %h",
                                   i, w_stall_req_o, rf_write_o, rf_value_o, exps[i]);
            end
            tick();
            dm_load_done_i = 1'b0;
        end
        // Randomized alignment against the reference model.
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 4))
                0: f = FUNC_LB; 1: f = FUNC_LH; 2: f = FUNC_LW; 3: f = FUNC_LBU; default: f = FUNC_LHU;
            endcase
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            e = ref_load(f, a, d);
            drive_x(1'b1, 5'd1, 1'b1, RD_SOURCE_LOAD, 32'h0, f, a);
            tick();
            drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
            dm_data_l_i = d; dm_load_done_i = 1'b1;
            #1;
            n_tests++;
            if ({rf_write_o, rf_value_o} !== {1'b1, e}) begin
                n_fail++; $display("FAIL load_rand f=%0d a=%0d d=%h: got wr=%b val=%h required 1 %h",
                                   f, a, d, rf_write_o, rf_value_o, e);
            end
            tick();
            dm_load_done_i = 1'b0;
        end
    endtask

    task automatic test_load_latency();
        int stalls = 0, writes = 0, held_bad = 0;
        bit fin = 0;
        drive_x(1'b1, 5'd7, 1'b1, RD_SOURCE_LOAD, 32'h0, FUNC_LW, 2'd0);
        tick();
        // Next instruction waits in X; it must not enter W while stalled.
        drive_x(1'b1, 5'd9, 1'b1, RD_SOURCE_ALU, 32'h0000_0099, 3'd0, 2'd0);
        dm_data_l_i = 32'hCAFE_F00D;
        for (int c = 0; c < 10 && !fin; c++) begin
            dm_load_done_i = (c == 3);
            #1;
            if (w_stall_req_o) stalls++;
            if (rf_rd_o !== 5'd7) held_bad++;
            if (rf_write_o) begin
                writes++;
                n_tests++;
                if ({rf_rd_o, rf_value_o} !== {5'd7, 32'hCAFE_F00D}) begin
                    n_fail++; $display("FAIL lat_write: got rd=%0d val=%h required 7 cafef00d", rf_rd_o, rf_value_o);
                end
            end
            if (!w_stall_req_o) fin = 1;
            else tick();
        end
        n_tests++;
        if (!fin || stalls != 3 || writes != 1 || held_bad != 0) begin
            n_fail++; $display("FAIL lat_count: got done=%0d stalls=%0d writes=%0d held_bad=%0d required 1 3 1 0",
                               fin, stalls, writes, held_bad);
        end
        tick();
        dm_load_done_i = 1'b0;
        drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
        #1;
        n_tests++;
        if ({rf_write_o, rf_rd_o, rf_value_o} !== {1'b1, 5'd9, 32'h0000_0099}) begin
            n_fail++; $display("FAIL lat_next: got wr=%b rd=%0d val=%h required 1 9 00000099",
                               rf_write_o, rf_rd_o, rf_value_o);
        end
        tick();
    endtask

    // done_at < 0: no data ever arrives; otherwise data arrives in that W cycle.
    task automatic test_timeout(input int done_at);
        logic es, ef, ew;
        drive_x(1'b1, 5'd12, 1'b1, RD_SOURCE_LOAD, 32'h0, FUNC_LW, 2'd0);
        tick();
        drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
        dm_data_l_i = 32'h1357_9BDF;
        for (int i = 0; i < 8; i++) begin
            dm_load_done_i = (i == done_at);
            #1;
            es = (done_at < 0) ? (i < 4) : (i < done_at);
            ef = (done_at < 0) && (i == 4);
            ew = (done_at >= 0) && (i == done_at);
            n_tests++;
            if ({w_stall_req_o, w_load_fault_o, rf_write_o} !== {es, ef, ew}) begin
                n_fail++; $display("FAIL timeout(done_at=%0d) cyc%0d: got stall/fault/write=%b required %b",
                                   done_at, i, {w_stall_req_o, w_load_fault_o, rf_write_o}, {es, ef, ew});
            end
            tick();
        end
        dm_load_done_i = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        drive_x(1'b1, 5'd14, 1'b1, RD_SOURCE_LOAD, 32'h0, FUNC_LW, 2'd0);
        tick();
        drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
        #1;
        n_tests++;
        if (w_stall_req_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got stall=%b required 1", w_stall_req_o);
        end
        dm_data_l_i = 32'h5A5A_5A5A; dm_load_done_i = 1'b1; rst_n_i = 1'b0;
        #1;
        n_tests++;
        if ({w_stall_req_o, rf_write_o, w_load_fault_o} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_async: got stall/write/fault=%b required 000",
                               {w_stall_req_o, rf_write_o, w_load_fault_o});
        end
        @(negedge clk_i);
        rst_n_i = 1'b1; dm_load_done_i = 1'b0;
        drive_x(1'b1, 5'd4, 1'b1, RD_SOURCE_ALU, 32'h4444_0004, 3'd0, 2'd0);
        tick();
        drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
        #1;
        n_tests++;
        if ({rf_write_o, rf_rd_o, rf_value_o, w_stall_req_o} !== {1'b1, 5'd4, 32'h4444_0004, 1'b0}) begin
            n_fail++; $display("FAIL rstmid_after: got wr=%b rd=%0d val=%h stall=%b required 1 4 44440004 0",
                               rf_write_o, rf_rd_o, rf_value_o, w_stall_req_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic        v, wr, ew;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [2:0]  f;
        logic [31:0] val, sh, mu, d, ev;
        int          lat;
        for (int n = 0; n < 40; n++) begin
            src = 2'($urandom_range(0, 3));
            v   = (src == RD_SOURCE_LOAD) ? 1'b1 : ($urandom_range(0, 4) != 0);
            rd  = 5'($urandom_range(0, 31));
            wr  = ($urandom_range(0, 5) != 0);
            val = $urandom; sh = $urandom; mu = $urandom; d = $urandom;
            f   = 3'($urandom_range(0, 7));
            drive_x(v, rd, wr, src, val, f, 2'($urandom_range(0, 3)));
            tick();
            dm_load_done_i = 1'b0;
            w_shifter_rd_i = sh; w_mul_rd_i = mu; dm_data_l_i = d;
            ew = v && wr && (rd != 5'd0);
            if (src != RD_SOURCE_LOAD) begin
                ev = (src == RD_SOURCE_ALU) ? val : (src == RD_SOURCE_SHIFTER) ? sh : mu;
                #1;
                n_tests++;
                if ({rf_write_o, w_bypass_rd_o, w_stall_req_o} !== {ew, ew ? rd : 5'd0, 1'b0} ||
                    (v && rf_value_o !== ev)) begin
                    n_fail++; $display("FAIL b2b%0d src=%0d: got wr=%b brd=%0d stall=%b val=%h required %b %0d 0 %h",
                                       n, src, rf_write_o, w_bypass_rd_o, w_stall_req_o, rf_value_o,
                                       ew, ew ? rd : 5'd0, ev);
                end
            end else begin
                ev  = ref_load(f, x_dm_addr_i, d);
                lat = $urandom_range(0, 3);
                for (int c = 0; c <= lat; c++) begin
                    dm_load_done_i = (c == lat);
                    #1;
                    n_tests++;
                    if ({w_stall_req_o, rf_write_o, w_bypass_rd_o} !==
                        {c < lat, ew && c == lat, (ew && c == lat) ? rd : 5'd0} ||
                        (ew && c == lat && rf_value_o !== ev)) begin
                        n_fail++; $display("FAIL b2b%0d load c=%0d lat=%0d: got stall=%b wr=%b brd=%0d val=%h required val %h",
                                           n, c, lat, w_stall_req_o, rf_write_o, w_bypass_rd_o, rf_value_o, ev);
                    end
                    if (c < lat) tick();
                end
            end
        end
        drive_x(1'b0, 5'd0, 1'b0, RD_SOURCE_ALU, 32'h0, 3'd0, 2'd0);
        tick();
        dm_load_done_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_shift();
        test_load_align();
        test_load_latency();
        test_timeout(-1);
        test_timeout(3);
        test_timeout(4);
        test_reset_mid_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/urv_writeback.md
Name: urv_writeback

Overview:
- Writeback (W) stage of the uRV pipeline, directly downstream of the two-stage barrel shifter and the execute stage.
- Captures the retiring instruction's result descriptor and selects the final rd value from ALU, shifter (stage-2 output), multiplier or load data.
- For loads, aligns and sign/zero-extends load data, stalls the pipe until memory returns, and drives the register-file write port and the W-stage bypass.

Parameters:
g_load_timeout, 0, cycles to wait for dm_load_done_i before flagging a fault; 0 disables the timeout counter.
g_timeout_width, 8, width of the timeout counter; g_load_timeout must be < 2**g_timeout_width.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
x_valid_i  in  1  execute stage presents an instruction to retire
x_stall_i  in  1  global pipeline stall (W register holds while high)
x_rd_i  in  5  destination register
x_rd_write_i  in  1  instruction writes rd
x_rd_source_i  in  2  result source: 0 ALU, 1 SHIFTER, 2 LOAD, 3 MUL
x_rd_value_i  in  32  ALU result
x_fun_i  in  3  load funct3 (LB/LH/LW/LBU/LHU)
x_dm_addr_i  in  2  load byte address bits [1:0]
w_shifter_rd_i  in  32  shifter stage-2 result, valid in the W cycle of a shift
w_mul_rd_i  in  32  multiplier result, valid in the W cycle of a multiply
dm_load_done_i  in  1  load data valid this cycle
dm_data_l_i  in  32  raw load word
w_stall_req_o  out  1  W requests a pipeline stall (load outstanding)
w_load_fault_o  out  1  one-cycle pulse: load timed out
rf_write_o  out  1  register-file write enable
rf_rd_o  out  5  register-file write index
rf_value_o  out  32  register-file write data
w_bypass_rd_o  out  5  rd of the instruction in W (0 when not writing)
w_bypass_value_o  out  32  value forwarded to decode/execute

Behaviour:
- W register: captures all x_* fields on posedge when !x_stall_i; w_valid <= x_valid_i. While x_stall_i is high, it holds.
- Reset (async, rst_n_i=0): w_valid=0, FSM=IDLE, timeout counter=0. Outputs are 0: w_stall_req_o, w_load_fault_o, rf_write_o, rf_rd_o, rf_value_o, w_bypass_rd_o, w_bypass_value_o.
- Source mux (combinational in W): ALU→x value, SHIFTER→w_shifter_rd_i, MUL→w_mul_rd_i, LOAD→aligned load data.
- Load align:
  - LB/LBU: byte addr[1:0], sign-/zero-extended.
  - LH/LHU: half selected by addr[1]; addr[0] ignored, since misalignment is trapped upstream.
  - LW and any other funct3: whole word.
- FSM states:
  - IDLE: non-load or no valid instruction. When a valid LOAD is captured → WAIT_LOAD.
  - WAIT_LOAD: w_stall_req_o = w_valid & !dm_load_done_i (combinational, so data arriving in the first W cycle causes no stall). On dm_load_done_i: write completes the same cycle; next state is IDLE, or WAIT_LOAD if another valid load is captured that edge.
- Write rule: rf_write_o = w_valid & x_rd_write & (rd != 0) & (source != LOAD | dm_load_done_i). rf_write_o is never asserted for rd=0.
- rf_rd_o and rf_value_o are combinational from the W register and the mux.
- Bypass: w_bypass_rd_o = rd when rf_write_o could be asserted, else 0. During WAIT_LOAD without data it is 0, so the hazard is resolved by stall.
- Timeout (g_load_timeout > 0):
  - The counter increments each WAIT_LOAD cycle without done.
  - At count == g_load_timeout: pulse w_load_fault_o, drop the stall, retire with no RF write, return to IDLE.
  - If done and timeout land on the same cycle, done wins (normal write, no fault).
- dm_load_done_i outside WAIT_LOAD is ignored.
- Reset asserted mid-WAIT_LOAD aborts the load silently: no write, stall released immediately (async).

Decomposition:
- urv_defs shared package:
  - funct3 constants FUNC_LB, FUNC_LH, FUNC_LW, FUNC_LBU, FUNC_LHU.
  - rd-source constants RD_SOURCE_ALU, RD_SOURCE_SHIFTER, RD_SOURCE_LOAD, RD_SOURCE_MUL.
- One natural sub-module: urv_load_align, purely combinational funct3/addr/data → 32-bit extended value.

Test Plan:
- ALU retire: ALU op, rd=5, value 0x1234_5678 → rf_write_o=1, rf_rd_o=5, rf_value_o=0x1234_5678 in the W cycle, no stall.
- Shift retire: SHIFTER source, rd=3, w_shifter_rd_i=0xFFFF_FF80 → rf_value_o=0xFFFF_FF80. rd=0 with any source → rf_write_o=0 and w_bypass_rd_o=0.
- Load alignment, dm_data_l_i=0x80FF_7F01:
  - LB addr=2 → 0xFFFF_FFFF
  - LBU addr=3 → 0x0000_0080
  - LH addr=2 → 0xFFFF_80FF
  - LHU addr=0 → 0x0000_7F01
  - LW → 0x80FF_7F01
- Load latency: done after 3 cycles → w_stall_req_o high exactly 3 cycles, W register held under x_stall_i, single write on the done cycle. Done in the first W cycle → zero stall cycles.
- Timeout: g_load_timeout=4, no done → stall for 4 cycles, then a one-cycle w_load_fault_o with no RF write and FSM back in IDLE. Repeat with done on the 4th cycle → normal write, no fault.
- Reset mid-load: rst_n_i low during WAIT_LOAD → w_stall_req_o and rf_write_o drop asynchronously. After release, the next ALU instruction retires normally.
